shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-cycle shift unit controller for the processor ALU.
- Performs a variable 32-bit logical-left, arithmetic-right or logical-right shift by 0–31.
- Works by sequencing a set of fixed-distance shift stages (16, 8, 4, 2, 1), applying one stage per clock.
- Sits beside the ALU; the pipeline stalls on `busy` and captures the result on `result_ready`.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.
- SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a shift; sampled only while idle.
- op  input  2  00 = SLL, 01 = SRA, 10 = SRL, 11 = SRL (reserved, treated as SRL).
- data_in  input  WIDTH  operand to shift.
- shamt  input  SHW  shift amount, 0–31.
- result  output  WIDTH  shifted value; held until the next accepted start.
- result_ready  output  1  one-cycle pulse when `result` becomes valid.
- busy  output  1  high while a shift is in progress.

Behaviour:
- States: IDLE and SHIFT. Reset state is IDLE.
- Reset values: result = 0, result_ready = 0, busy = 0, internal accumulator = 0, remaining amount = 0, latched op = 00.
- Reset is synchronous and takes priority over everything else. Reset asserted mid-operation aborts the shift:
  - next state IDLE;
  - all outputs return to reset values;
  - no result_ready pulse is produced for the aborted operation.
- IDLE, start = 1 at an edge:
  - latch data_in into the accumulator, shamt into the remaining amount, and op;
  - next state SHIFT; busy = 1 from the next cycle;
  - result_ready deasserts (it is a pulse).
- IDLE, start = 0: hold all registers; result keeps its last value.
- SHIFT, remaining ≠ 0 at an edge:
  - find the highest set bit k of remaining;
  - shift the accumulator by 2^k in the latched direction;
  - clear bit k of remaining;
  - stay in SHIFT.
- SHIFT, remaining = 0 at an edge:
  - result ← accumulator;
  - result_ready = 1 for exactly one cycle;
  - busy = 0; next state IDLE.
- Latency: result_ready is asserted popcount(shamt) + 1 edges after the edge that accepted start.
  - Minimum: shamt = 0 gives 1 edge.
  - Maximum: shamt = 31 gives 6 edges.
- Fill rules per stage:
  - SLL fills vacated LSBs with 0.
  - SRL fills vacated MSBs with 0.
  - SRA replicates accumulator bit 31 into vacated MSBs, including for the 2-bit stage.
- start while busy = 1 is ignored: no queueing, and the in-flight operands are unchanged.
- start in the same cycle result_ready = 1: the FSM is already IDLE, so the request is accepted. result_ready drops on the next cycle and result holds the previous value until the new completion.
- data_in, op and shamt may change freely after acceptance; only latched copies are used.
- No overflow or flag outputs; bits shifted out are discarded.

Test Plan:
- Reset, then op = 01, data_in = 0x80000000, shamt = 2, start one cycle -> busy high for 2 cycles; result_ready pulses on edge 2; result = 0xE0000000.
- op = 00, data_in = 0x00000001, shamt = 31 -> result_ready on edge 6 (16, 8, 4, 2, 1 stages); result = 0x80000000; busy high 6 cycles.
- op = 10, data_in = 0xF0000000, shamt = 4 -> result = 0x0F000000 on edge 2. Repeat with op = 01 -> result = 0xFF000000. Repeat with op = 11 -> 0x0F000000.
- shamt = 0, data_in = 0x12345678, op = 01 -> result = 0x12345678 with result_ready on edge 1. Also issue start on the ready cycle with data_in = 0x7FFFFFFF, shamt = 5, op = 01 -> accepted; result = 0x03FFFFFF three edges later.
- While busy on a shamt = 31 shift, pulse start with data_in = 0xFFFFFFFF -> ignored; the original operation completes with its own value.
- Assert reset on the third cycle of a shamt = 31 operation -> next cycle busy = 0, result = 0, result_ready = 0, and no later pulse. A fresh start then completes normally.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 32-bit SLL/SRA/SRL unit. One fixed-distance
// stage (16, 8, 4, 2, 1) is applied per clock, chosen by the highest set
// bit of the remaining shift amount.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic             result_ready,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_rem;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_ready;
  logic [SHW-1:0]   w_step;
  logic [WIDTH-1:0] w_shifted;

  // State register; reset returns to IDLE and aborts any shift.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = SHIFT;
      SHIFT:   if (r_rem == '0) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs decoded from state and registered datapath.
  always_comb begin
    busy         = (r_state == SHIFT);
    result       = r_result;
    result_ready = r_ready;
  end

  // One-hot mask of the highest set bit of the remaining amount; later
  // iterations overwrite earlier ones, so the MSB wins. Its value is also
  // the stage distance 2^k.
  always_comb begin
    w_step = '0;
    for (int unsigned i = 0; i < SHW; i++) begin
      if (r_rem[i]) begin
        w_step    = '0;
        w_step[i] = 1'b1;
      end
    end
  end

  // Apply the single selected fixed-distance stage in the latched direction.
  always_comb begin
    w_shifted = r_acc;
    for (int unsigned i = 0; i < SHW; i++) begin
      if (w_step[i]) begin
        case (r_op)
          2'b00:   w_shifted = r_acc << (1 << i);
          2'b01:   w_shifted = WIDTH'($signed(r_acc) >>> (1 << i));
          default: w_shifted = r_acc >> (1 << i);
        endcase
      end
    end
  end

  // Datapath: latch operands on accept, step the accumulator, publish result.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc    <= '0;
      r_rem    <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          if (start) begin
            r_acc <= data_in;
            r_rem <= shamt;
            r_op  <= op;
          end
        end
        SHIFT: begin
          if (r_rem != '0) begin
            r_acc <= w_shifted;
            r_rem <= r_rem & ~w_step;
          end else begin
            r_result <= r_acc;
            r_ready  <= 1'b1;
          end
        end
        default: r_ready <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with hand-computed expected results.
module tb_shift_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        result_ready;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] prev_res;

  shift_sequencer #(.WIDTH(32), .SHW(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .data_in      (data_in),
    .shamt        (shamt),
    .result       (result),
    .result_ready (result_ready),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one shift and follow it to completion. inj > 0 pulses a
  // conflicting start that many edges after acceptance (must be ignored).
  // Returns at the sample point of the result_ready cycle.
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] d,
                     input logic [4:0] s, input logic [31:0] exp, input int exp_lat,
                     input int inj);
    int lat;
    op = o; data_in = d; shamt = s; start = 1'b1;
    step();
    start = 1'b0;
    op = ~o; data_in = ~d; shamt = ~s;
    chk({tag, "_accept_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_accept_rdy"}, {31'd0, result_ready}, 32'd0);
    chk({tag, "_held_result"}, result, prev_res);
    lat = 0;
    do begin
      if (inj != 0 && lat == inj) begin
        start = 1'b1; data_in = 32'hFFFF_FFFF; shamt = 5'd0; op = 2'b00;
      end
      step();
      start = 1'b0;
      lat++;
      if (!result_ready && lat < 12)
        chk({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
    end while (!result_ready && lat < 12);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_result"}, result, exp);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    prev_res = exp;
  endtask

  task automatic idle_check(input string tag);
    step();
    chk({tag, "_rdy_pulse"}, {31'd0, result_ready}, 32'd0);
    chk({tag, "_hold"}, result, prev_res);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; op = 2'b00; data_in = '0; shamt = '0;
    prev_res = 32'd0;
    step(); step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdy", {31'd0, result_ready}, 32'd0);
    chk("rst_result", result, 32'd0);
    reset = 1'b0;
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    run("sra2", 2'b01, 32'h8000_0000, 5'd2, 32'hE000_0000, 2, 0);
    idle_check("sra2");
    run("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 6, 0);
    idle_check("sll31");
    run("srl4", 2'b10, 32'hF000_0000, 5'd4, 32'h0F00_0000, 2, 0);
    run("sra4", 2'b01, 32'hF000_0000, 5'd4, 32'hFF00_0000, 2, 0);
    run("op11", 2'b11, 32'hF000_0000, 5'd4, 32'h0F00_0000, 2, 0);
    idle_check("op11");
    run("sra31", 2'b01, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 6, 0);
    run("sll_mix", 2'b00, 32'h1234_5678, 5'd12, 32'h4567_8000, 3, 0);
    idle_check("sll_mix");

    // shamt 0 completes in one edge; next start issued on the ready cycle
    run("zero", 2'b01, 32'h1234_5678, 5'd0, 32'h1234_5678, 1, 0);
    run("b2b", 2'b01, 32'h7FFF_FFFF, 5'd5, 32'h03FF_FFFF, 3, 0);
    idle_check("b2b");

    // start while busy is ignored; SRL of MSB by 31 leaves bit 0
    run("ignore", 2'b10, 32'h8000_0000, 5'd31, 32'h0000_0001, 6, 2);
    idle_check("ignore");

    // reset on third cycle of a long shift aborts it
    op = 2'b00; data_in = 32'h0000_0001; shamt = 5'd31; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rdy", {31'd0, result_ready}, 32'd0);
    chk("abort_result", result, 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (result_ready) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    prev_res = 32'd0;
    run("post_abort", 2'b00, 32'h0000_ABCD, 5'd8, 32'h00AB_CD00, 2, 0);
    idle_check("post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
